tmp2_temp_formatter: RTL and testbench

TMP2_TEMP_FORMATTER -- requirements
Module: tmp2_temp_formatter

---
 rtl/tmp2_temp_formatter.sv | 254 +++++++++++++++++++++++++
 tb/tb_tmp2_temp_formatter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tmp2_temp_formatter.sv
// tmp2_temp_formatter: converts raw TMP2 temperature samples into sign,
// saturated BCD digits (hundreds/tens/ones/tenths) and an overflow flag,
// with a single pending slot for samples arriving during a conversion and
// optional raw min/max trackers.
//
// Optional feature macro: TMP2_FMT_MINMAX_EN (min/max trackers).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a sample
// ABS    | register sign and 17-bit magnitude of the working sample
// FRAC   | derive tenths and integer part, saturate at 199.9 degC
// DABBLE | 8 shift/add-3 iterations on the 8-bit integer part
// OUT    | outputs valid for one cycle, then load next sample or idle
module tmp2_temp_formatter (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [15:0] temperature_i,
    input  logic        resolution,
    input  logic        clear_minmax,
    output logic        busy_o,
    output logic        valid_o,
    output logic        sign_o,
    output logic [3:0]  hundreds_o,
    output logic [3:0]  tens_o,
    output logic [3:0]  ones_o,
    output logic [3:0]  tenths_o,
    output logic        ovf_o,
    output logic        overrun_o,
    output logic [15:0] min_o,
    output logic [15:0] max_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS    = 3'd1,
        FRAC   = 3'd2,
        DABBLE = 3'd3,
        OUT    = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] work_q, work_d;
    logic        wsign_q, wsign_d;
    logic [16:0] mag_q, mag_d;
    logic [3:0]  wtenths_q, wtenths_d;
    logic        wovf_q, wovf_d;
    logic [19:0] dab_q, dab_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        overrun_q, overrun_d;

    logic        sign_q, sign_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tenths_q, tenths_d;
    logic        ovf_q, ovf_d;

    logic [15:0] masked;
    logic [16:0] sext;
    logic [10:0] frac_prod;
    logic [9:0]  int_raw;
    logic [19:0] dab_adj;
    logic [19:0] dab_next;
    logic        cap_en;
    logic [15:0] cap_val;

    // 13-bit format carries flags in the low three bits; drop them
    assign masked    = resolution ? temperature_i : {temperature_i[15:3], 3'b000};
    assign sext      = {work_q[15], work_q};
    assign frac_prod = {4'b0000, mag_q[6:0]} * 11'd10;
    assign int_raw   = mag_q[16:7];

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift left
    always_comb begin
        dab_adj = dab_q;
        if (dab_q[19:16] >= 4'd5) dab_adj[19:16] = dab_q[19:16] + 4'd3;
        if (dab_q[15:12] >= 4'd5) dab_adj[15:12] = dab_q[15:12] + 4'd3;
        if (dab_q[11:8]  >= 4'd5) dab_adj[11:8]  = dab_q[11:8]  + 4'd3;
        dab_next = {dab_adj[18:0], 1'b0};
    end

    // Next-state, datapath and pending-slot logic
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        wsign_d    = wsign_q;
        mag_d      = mag_q;
        wtenths_d  = wtenths_q;
        wovf_d     = wovf_q;
        dab_d      = dab_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overrun_d  = overrun_q;
        sign_d     = sign_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        tenths_d   = tenths_q;
        ovf_d      = ovf_q;
        cap_en     = 1'b0;
        cap_val    = masked;

        // Mid-conversion arrivals go to the pending slot; OUT handles its own
        if (valid_i && (state_q != IDLE) && (state_q != OUT)) begin
            pend_d     = masked;
            pend_vld_d = 1'b1;
            if (pend_vld_q) overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    work_d  = masked;
                    cap_en  = 1'b1;
                    state_d = ABS;
                end
            end
            ABS: begin
                wsign_d = work_q[15];
                mag_d   = work_q[15] ? (~sext + 17'd1) : sext;
                state_d = FRAC;
            end
            FRAC: begin
                cnt_d = 3'd0;
                if (int_raw > 10'd199) begin
                    wovf_d    = 1'b1;
                    wtenths_d = 4'd9;
                    dab_d     = {12'h000, 8'd199};
                end else begin
                    wovf_d    = 1'b0;
                    wtenths_d = frac_prod[10:7];
                    dab_d     = {12'h000, int_raw[7:0]};
                end
                state_d = DABBLE;
            end
            DABBLE: begin
                dab_d = dab_next;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    sign_d   = wsign_q;
                    hund_d   = dab_next[19:16];
                    tens_d   = dab_next[15:12];
                    ones_d   = dab_next[11:8];
                    tenths_d = wtenths_q;
                    ovf_d    = wovf_q;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (valid_i) begin
                    work_d     = masked;
                    cap_en     = 1'b1;
                    pend_vld_d = 1'b0;
                    if (pend_vld_q) overrun_d = 1'b1;
                    state_d    = ABS;
                end else if (pend_vld_q) begin
                    work_d     = pend_q;
                    cap_en     = 1'b1;
                    cap_val    = pend_q;
                    pend_vld_d = 1'b0;
                    state_d    = ABS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Working, pending and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q     <= 16'h0000;
            wsign_q    <= 1'b0;
            mag_q      <= 17'h00000;
            wtenths_q  <= 4'h0;
            wovf_q     <= 1'b0;
            dab_q      <= 20'h00000;
            cnt_q      <= 3'd0;
            pend_q     <= 16'h0000;
            pend_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
            sign_q     <= 1'b0;
            hund_q     <= 4'h0;
            tens_q     <= 4'h0;
            ones_q     <= 4'h0;
            tenths_q   <= 4'h0;
            ovf_q      <= 1'b0;
        end else begin
            work_q     <= work_d;
            wsign_q    <= wsign_d;
            mag_q      <= mag_d;
            wtenths_q  <= wtenths_d;
            wovf_q     <= wovf_d;
            dab_q      <= dab_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            overrun_q  <= overrun_d;
            sign_q     <= sign_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tenths_q   <= tenths_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef TMP2_FMT_MINMAX_EN
    logic [15:0] min_q, max_q;

    // Min/max trackers; a clear strobe wins over a same-cycle capture
    always_ff @(posedge clk) begin
        if (rst || clear_minmax) begin
            min_q <= 16'h7FFF;
            max_q <= 16'h8000;
        end else if (cap_en) begin
            if ($signed(cap_val) < $signed(min_q)) min_q <= cap_val;
            if ($signed(cap_val) > $signed(max_q)) max_q <= cap_val;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    logic unused_minmax;
    assign unused_minmax = ^{cap_en, cap_val, clear_minmax};
    assign min_o = 16'h0000;
    assign max_o = 16'h0000;
`endif

    assign busy_o     = (state_q != IDLE);
    assign valid_o    = (state_q == OUT);
    assign sign_o     = sign_q;
    assign hundreds_o = hund_q;
    assign tens_o     = tens_q;
    assign ones_o     = ones_q;
    assign tenths_o   = tenths_q;
    assign ovf_o      = ovf_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_tmp2_temp_formatter.sv
// Directed bench for tmp2_temp_formatter; expected values are hand-computed.
module tb_tmp2_temp_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [15:0] temperature_i;
    logic        resolution;
    logic        clear_minmax;
    logic        busy_o, valid_o, sign_o, ovf_o, overrun_o;
    logic [3:0]  hundreds_o, tens_o, ones_o, tenths_o;
    logic [15:0] min_o, max_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tmp2_temp_formatter dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .temperature_i(temperature_i),
        .resolution   (resolution),
        .clear_minmax (clear_minmax),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .sign_o       (sign_o),
        .hundreds_o   (hundreds_o),
        .tens_o       (tens_o),
        .ones_o       (ones_o),
        .tenths_o     (tenths_o),
        .ovf_o        (ovf_o),
        .overrun_o    (overrun_o),
        .min_o        (min_o),
        .max_o        (max_o)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {hundreds_o, tens_o, ones_o, tenths_o};
    endfunction

    // Issue one sample from IDLE, measure latency, check the result
    task automatic convert(input string tag, input logic [15:0] t, input logic res,
                           input logic exp_sign, input logic [15:0] exp_dig, input logic exp_ovf);
        int n;
        n = 0;
        temperature_i = t;
        resolution    = res;
        valid_i       = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (valid_o) begin
                n = i;
                break;
            end
        end
        chk_eq({tag, "_lat"}, n, 10);
        chk_eq({tag, "_sign"}, sign_o, exp_sign);
        chk_eq({tag, "_dig"}, digits(), exp_dig);
        chk_eq({tag, "_ovf"}, ovf_o, exp_ovf);
        @(posedge clk); #1;
        chk_eq({tag, "_vld_lo"}, valid_o, 1'b0);
        chk_eq({tag, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin : main
        int pulses;
        int lat1, lat2;
        logic [16:0] res1, res2;

        rst = 1'b1; valid_i = 1'b0; temperature_i = 16'h0000;
        resolution = 1'b1; clear_minmax = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk_eq("rst_busy", busy_o, 1'b0);
        chk_eq("rst_valid", valid_o, 1'b0);
        chk_eq("rst_sign", sign_o, 1'b0);
        chk_eq("rst_dig", digits(), 16'h0000);
        chk_eq("rst_ovf", ovf_o, 1'b0);
        chk_eq("rst_overrun", overrun_o, 1'b0);
`ifdef TMP2_FMT_MINMAX_EN
        chk_eq("rst_min", min_o, 16'h7FFF);
        chk_eq("rst_max", max_o, 16'h8000);
`else
        chk_eq("rst_min", min_o, 16'h0000);
        chk_eq("rst_max", max_o, 16'h0000);
`endif

        convert("t25_0",   16'h0C80, 1'b1, 1'b0, 16'h0250, 1'b0);
        convert("t25_5m",  16'h0CC7, 1'b0, 1'b0, 16'h0255, 1'b0);
        convert("negzero", 16'hFFFA, 1'b1, 1'b1, 16'h0000, 1'b0);
        convert("t199_9",  16'h63FF, 1'b1, 1'b0, 16'h1999, 1'b0);
        convert("t200_0",  16'h6400, 1'b1, 1'b0, 16'h1999, 1'b1);
        convert("t_m256",  16'h8000, 1'b1, 1'b1, 16'h1999, 1'b1);
        chk_eq("no_overrun", overrun_o, 1'b0);

        clear_minmax = 1'b1;
        @(posedge clk); #1;
        clear_minmax = 1'b0;
`ifdef TMP2_FMT_MINMAX_EN
        chk_eq("clr_min", min_o, 16'h7FFF);
        chk_eq("clr_max", max_o, 16'h8000);
`endif

        convert("t_m0_5",  16'hFFC0, 1'b1, 1'b1, 16'h0005, 1'b0);
        convert("t150_0",  16'h4B00, 1'b1, 1'b0, 16'h1500, 1'b0);
`ifdef TMP2_FMT_MINMAX_EN
        chk_eq("mm_min", min_o, 16'hFFC0);
        chk_eq("mm_max", max_o, 16'h4B00);
`else
        chk_eq("mm_min", min_o, 16'h0000);
        chk_eq("mm_max", max_o, 16'h0000);
`endif

        // Three samples at E0, E2, E4: second one is overwritten by the third
        pulses = 0; lat1 = 0; lat2 = 0; res1 = '0; res2 = '0;
        resolution = 1'b1;
        temperature_i = 16'h0C80; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        @(posedge clk); #1 temperature_i = 16'h4B00; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        @(posedge clk); #1 temperature_i = 16'hFFC0; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        for (int i = 5; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid_o) begin
                pulses++;
                if (pulses == 1) begin lat1 = i; res1 = {sign_o, digits()}; end
                if (pulses == 2) begin lat2 = i; res2 = {sign_o, digits()}; end
            end
        end
        chk_eq("ovr_pulses", pulses, 2);
        chk_eq("ovr_lat1", lat1, 10);
        chk_eq("ovr_lat2", lat2, 21);
        chk_eq("ovr_res1", res1, 17'h00250);
        chk_eq("ovr_res2", res2, 17'h10005);
        chk_eq("ovr_flag", overrun_o, 1'b1);
        chk_eq("ovr_idle", busy_o, 1'b0);

        // Reset at E5 of a conversion, with a valid_i in the reset cycle
        temperature_i = 16'h0C80; valid_i = 1'b1;
        @(posedge clk); #1 valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; valid_i = 1'b1; temperature_i = 16'h4B00;
        @(posedge clk); #1 rst = 1'b0; valid_i = 1'b0;
        chk_eq("abort_busy", busy_o, 1'b0);
        chk_eq("abort_sign", sign_o, 1'b0);
        chk_eq("abort_dig", digits(), 16'h0000);
        chk_eq("abort_ovf", ovf_o, 1'b0);
        chk_eq("abort_overrun", overrun_o, 1'b0);
`ifdef TMP2_FMT_MINMAX_EN
        chk_eq("abort_min", min_o, 16'h7FFF);
        chk_eq("abort_max", max_o, 16'h8000);
`endif
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid_o) pulses++;
        end
        chk_eq("abort_novalid", pulses, 0);
        chk_eq("abort_still_idle", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
